// File: rtl/wg_exec_mask_seq.sv
// Splits a workgroup's thread count into 64-lane wavefronts and emits one
// execute mask per wavefront; only the final wavefront may carry a partial mask.
module wg_exec_mask_seq #(
  parameter int CNT_WIDTH    = 11,
  parameter int MAX_WF       = 16,
  parameter int WF_IDX_WIDTH = 4,
  parameter int WG_ID_WIDTH  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    start_ready,
  input  logic [CNT_WIDTH-1:0]    thread_count,
  input  logic [WG_ID_WIDTH-1:0]  wg_id,
  output logic                    wf_valid,
  input  logic                    wf_ready,
  output logic [63:0]             wf_exec_mask,
  output logic [WF_IDX_WIDTH-1:0] wf_index,
  output logic [CNT_WIDTH-1:0]    wf_base_thread,
  output logic [WG_ID_WIDTH-1:0]  wf_wg_id,
  output logic                    wf_last,
  output logic                    done,
  output logic                    done_err
);

  localparam int MAX_THREADS = MAX_WF * 64;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] rem;
  logic [CNT_WIDTH-1:0] rem_next;
  logic                 illegal;

  // rem is never zero in ISSUE, so the partial branch always yields 1..63 lanes
  function automatic logic [63:0] mask_of(input logic [CNT_WIDTH-1:0] r);
    if (r >= CNT_WIDTH'(64))
      return '1;
    else
      return (64'd1 << r[5:0]) - 64'd1;
  endfunction

  assign rem_next = (rem > CNT_WIDTH'(64)) ? rem - CNT_WIDTH'(64) : '0;
  assign illegal  = (thread_count == '0) || (thread_count > CNT_WIDTH'(MAX_THREADS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rem            <= '0;
      start_ready    <= 1'b1;
      wf_valid       <= 1'b0;
      wf_exec_mask   <= '0;
      wf_index       <= '0;
      wf_base_thread <= '0;
      wf_wg_id       <= '0;
      wf_last        <= 1'b0;
      done           <= 1'b0;
      done_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wf_wg_id       <= wg_id;
            rem            <= thread_count;
            wf_index       <= '0;
            wf_base_thread <= '0;
            wf_exec_mask   <= mask_of(thread_count);
            wf_last        <= (thread_count <= CNT_WIDTH'(64));
            start_ready    <= 1'b0;
            if (illegal) begin
              state    <= DONE;
              done     <= 1'b1;
              done_err <= 1'b1;
            end else begin
              state    <= ISSUE;
              wf_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (wf_ready) begin
            rem <= rem_next;
            if (wf_last) begin
              state    <= DONE;
              wf_valid <= 1'b0;
              done     <= 1'b1;
              done_err <= 1'b0;
            end else begin
              wf_exec_mask   <= mask_of(rem_next);
              wf_last        <= (rem_next <= CNT_WIDTH'(64));
              wf_index       <= wf_index + WF_IDX_WIDTH'(1);
              wf_base_thread <= wf_base_thread + CNT_WIDTH'(64);
            end
          end
        end
        DONE: begin
          done        <= 1'b0;
          done_err    <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
